// File: rtl/lram_sched_pkg.sv
// ---------------------------------------------------------------------------
// lram_sched_pkg
// Shared types and helpers for the LRAM write scheduler.
//   - Default sizing of the matrix-vector array (6 lanes, 32 rows per bank).
//   - Lane-count and row typedefs at the default sizing, plus the bank index.
//   - clamp_lanes(): maps an out-of-range lane request onto the maximum.
// Instances with non-default M/DEPTH derive their own widths locally from
// the same clog2 rules.
// ---------------------------------------------------------------------------
package lram_sched_pkg;

    localparam int unsigned LRAM_M_DEF     = 6;
    localparam int unsigned LRAM_DEPTH_DEF = 32;

    localparam int unsigned LANE_W_DEF = $clog2(LRAM_M_DEF + 1);
    localparam int unsigned ROW_W_DEF  = $clog2(LRAM_DEPTH_DEF);

    typedef logic [LANE_W_DEF-1:0] lane_cnt_t;
    typedef logic [ROW_W_DEF-1:0]  row_t;
    typedef logic                  bank_idx_t;

    // A request of zero lanes, or more lanes than exist, means "all lanes".
    function automatic int unsigned clamp_lanes(input int unsigned req,
                                                input int unsigned max_lanes);
        return ((req == 0) || (req > max_lanes)) ? max_lanes : req;
    endfunction

endpackage

// File: rtl/lram_bank_tracker.sv
// ---------------------------------------------------------------------------
// lram_bank_tracker
// Keeps the per-bank full flags and hands banks back in closing order.
// Ports:
//   i_clk, i_reset_n  clock, synchronous active-low reset
//   i_close           a bank is being closed this cycle
//   i_close_bank      index of the bank being closed
//   i_release         consumer is done with the oldest full bank
//   i_fill_bank       fill bank as it will be after this cycle
//   i_ovf_event       a write was due into a full bank
//   o_full            registered full flags (bit 1 unused when PINGPONG=0)
//   o_stall           registered full flag of the fill bank
//   o_overflow        sticky overflow flag
// ---------------------------------------------------------------------------
module lram_bank_tracker
    import lram_sched_pkg::*;
#(
    parameter int PINGPONG = 1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_close,
    input  bank_idx_t  i_close_bank,
    input  logic       i_release,
    input  bank_idx_t  i_fill_bank,
    input  logic       i_ovf_event,
    output logic [1:0] o_full,
    output logic       o_stall,
    output logic       o_overflow
);

    logic [1:0] full_q, full_d;
    bank_idx_t  rel_ptr_q, rel_ptr_d;
    logic       stall_q, stall_d;
    logic       overflow_q, overflow_d;

    always_comb begin
        full_d     = full_q;
        rel_ptr_d  = rel_ptr_q;
        // Release acts on the flags as they stood before this cycle's close,
        // so a release with nothing full is dropped even if a close lands now.
        if (i_release && (full_q != 2'b00)) begin
            full_d[rel_ptr_q] = 1'b0;
            if (PINGPONG != 0) begin
                rel_ptr_d = ~rel_ptr_q;
            end
        end
        if (i_close) begin
            full_d[i_close_bank] = 1'b1;
        end
        // Looking at next-state values keeps o_stall exactly one cycle behind
        // the close/release that caused it.
        stall_d    = full_d[i_fill_bank];
        overflow_d = overflow_q | i_ovf_event;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            full_q     <= 2'b00;
            rel_ptr_q  <= 1'b0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            rel_ptr_q  <= rel_ptr_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_full     = full_q;
    assign o_stall    = stall_q;
    assign o_overflow = overflow_q;

endmodule

// File: rtl/lram_wr_sched.sv
// ---------------------------------------------------------------------------
// lram_wr_sched
// Write scheduler for up to M LRAM lanes fed by the systolic data chain.
// Every N unpaused active cycles one row is written to all active lanes at
// {bank, row}; full banks are handed to the reader via bank_done/release.
// Ports:
//   i_clk, i_reset_n  clock, synchronous active-low reset
//   i_num_lanes       requested lane count N (latched while i_active is low)
//   i_active          stream in progress
//   i_pause           chain stall; schedule freezes
//   i_release         consumer frees the oldest full bank
//   o_wren            per-lane write enables (lanes >= N stay 0)
//   o_wraddr          shared write address {bank, row}, zero-extended
//   o_stall           current fill bank is full
//   o_bank_done       one-cycle pulse when a bank is closed
//   o_done_bank       index of the closed bank
//   o_done_rows       rows written into the closed bank
//   o_overflow        sticky: a write fell due while the fill bank was full
// ---------------------------------------------------------------------------
module lram_wr_sched
    import lram_sched_pkg::*;
#(
    parameter int M        = 6,
    parameter int DEPTH    = 32,
    parameter int PINGPONG = 1,
    parameter int A        = 6
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic [$clog2(M+1)-1:0]     i_num_lanes,
    input  logic                       i_active,
    input  logic                       i_pause,
    input  logic                       i_release,
    output logic [M-1:0]               o_wren,
    output logic [A-1:0]               o_wraddr,
    output logic                       o_stall,
    output logic                       o_bank_done,
    output logic                       o_done_bank,
    output logic [$clog2(DEPTH+1)-1:0] o_done_rows,
    output logic                       o_overflow
);

    localparam int LW = $clog2(M + 1);
    localparam int CW = $clog2(M);
    localparam int RW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH + 1);

    logic [LW-1:0] n_q, n_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;
    bank_idx_t     bank_q, bank_d;
    logic [M-1:0]  wren_q, wren_d;
    logic [A-1:0]  wraddr_q, wraddr_d;
    logic          done_q, done_d;
    bank_idx_t     done_bank_q, done_bank_d;
    logic [DW-1:0] done_rows_q, done_rows_d;

    logic [M-1:0]  lane_mask;
    logic [1:0]    full;
    logic          close;
    logic          ovf_event;
    int unsigned   n_req;

    // The bank bit only exists in the address when banking is enabled.
    function automatic logic [A-1:0] make_addr(input bank_idx_t b,
                                               input logic [RW-1:0] r);
        logic [RW:0] banked;
        banked = {b, r};
        if (PINGPONG != 0) begin
            return A'(banked);
        end
        return A'(r);
    endfunction

    always_comb begin
        for (int i = 0; i < M; i++) begin
            lane_mask[i] = (i < int'(n_q));
        end
    end

    always_comb begin
        n_d         = n_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        bank_d      = bank_q;
        wren_d      = '0;
        wraddr_d    = wraddr_q;
        done_d      = 1'b0;
        done_bank_d = done_bank_q;
        done_rows_d = done_rows_q;
        close       = 1'b0;
        ovf_event   = 1'b0;
        n_req       = clamp_lanes(32'(i_num_lanes), M);

        if (!i_active) begin
            // Idle: track the lane request and preload the counter so the
            // first active cycle already counts down from N-1.
            n_d   = LW'(n_req);
            cnt_d = CW'(n_req - 1);
            if (row_q != '0) begin
                close       = 1'b1;
                done_rows_d = DW'(row_q);
                row_d       = '0;
            end
        end else if (!i_pause) begin
            if (cnt_q == '0) begin
                cnt_d = CW'(n_q - LW'(1));
                if (full[bank_q]) begin
                    ovf_event = 1'b1;
                end else begin
                    wren_d   = lane_mask;
                    wraddr_d = make_addr(bank_q, row_q);
                    if (row_q == RW'(DEPTH - 1)) begin
                        close       = 1'b1;
                        done_rows_d = DW'(DEPTH);
                        row_d       = '0;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        if (close) begin
            done_d      = 1'b1;
            done_bank_d = bank_q;
            if (PINGPONG != 0) begin
                bank_d = ~bank_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            n_q         <= LW'(M);
            cnt_q       <= CW'(M - 1);
            row_q       <= '0;
            bank_q      <= 1'b0;
            wren_q      <= '0;
            wraddr_q    <= '0;
            done_q      <= 1'b0;
            done_bank_q <= 1'b0;
            done_rows_q <= '0;
        end else begin
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            bank_q      <= bank_d;
            wren_q      <= wren_d;
            wraddr_q    <= wraddr_d;
            done_q      <= done_d;
            done_bank_q <= done_bank_d;
            done_rows_q <= done_rows_d;
        end
    end

    lram_bank_tracker #(
        .PINGPONG (PINGPONG)
    ) u_tracker (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_close      (close),
        .i_close_bank (bank_q),
        .i_release    (i_release),
        .i_fill_bank  (bank_d),
        .i_ovf_event  (ovf_event),
        .o_full       (full),
        .o_stall      (o_stall),
        .o_overflow   (o_overflow)
    );

    assign o_wren      = wren_q;
    assign o_wraddr    = wraddr_q;
    assign o_bank_done = done_q;
    assign o_done_bank = done_bank_q;
    assign o_done_rows = done_rows_q;

endmodule
